// File: rtl/trig_drp_sequencer.sv
// rtl/trig_drp_sequencer.sv - DRP read / read-modify-write sequencer with MMCM reset handling
//
// Optional build macro: TRIG_DRP_LOCK_WAIT_EN
//   defined   : after releasing mmcm_reset, wait for mmcm_locked (bounded by pLOCK_TIMEOUT)
//   undefined : REL goes straight to DONE; mmcm_locked and pLOCK_TIMEOUT are not used
//
// Ports:
//   usb_clk, reset_n           sole clock (DRP dclk domain), async active-low reset
//   I_start                    one-cycle request, honoured only when idle
//   I_rd_only                  1 = read only, 0 = read-modify-write
//   I_addr, I_mask, I_data     DRP address, keep-mask (1 = keep bit), new bit values
//   O_busy, O_done             busy level, one-cycle completion pulse
//   O_rdata, O_error           last DRP read value, sticky timeout flag
//   drp_addr/den/dwe/din       DRP master request outputs
//   drp_dout, drp_drdy         DRP responses
//   mmcm_reset, mmcm_locked    MMCM reset (active-high) and lock status

module trig_drp_sequencer #(
    parameter int pDRDY_TIMEOUT = 64,
    parameter int pLOCK_TIMEOUT = 65535
) (
    input  logic        usb_clk,
    input  logic        reset_n,
    input  logic        I_start,
    input  logic        I_rd_only,
    input  logic [6:0]  I_addr,
    input  logic [15:0] I_mask,
    input  logic [15:0] I_data,
    output logic        O_busy,
    output logic        O_done,
    output logic [15:0] O_rdata,
    output logic        O_error,
    output logic [6:0]  drp_addr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_din,
    input  logic [15:0] drp_dout,
    input  logic        drp_drdy,
    output logic        mmcm_reset,
    input  logic        mmcm_locked
);

`ifdef TRIG_DRP_LOCK_WAIT_EN
    localparam int MAX_TO = (pDRDY_TIMEOUT > pLOCK_TIMEOUT) ? pDRDY_TIMEOUT : pLOCK_TIMEOUT;
`else
    localparam int MAX_TO = pDRDY_TIMEOUT;
    localparam int unused_lock_timeout = pLOCK_TIMEOUT;
    logic unused_locked;
    assign unused_locked = mmcm_locked;
`endif
    localparam int CNT_W = $clog2(MAX_TO + 1);

    // The counter starts at 0 on the first cycle of a wait state, so expiry is
    // detected while it holds TIMEOUT-1: the wait state lasts exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(pDRDY_TIMEOUT - 1);
`ifdef TRIG_DRP_LOCK_WAIT_EN
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(pLOCK_TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_REL,
        S_LOCK_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              rd_only_q;
    logic [15:0]       mask_q;
    logic [15:0]       data_q;

    logic              accept;
    logic              rd_capture;
    logic              wait_expired;
    logic              in_wait;

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        rd_capture   = 1'b0;
        wait_expired = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_start) begin
                    accept     = 1'b1;
                    next_state = I_rd_only ? S_RD_REQ : S_RST;
                end
            end
            S_RST:    next_state = S_RD_REQ;
            S_RD_REQ: next_state = S_RD_WAIT;
            S_RD_WAIT: begin
                // drdy wins over expiry on the same edge
                if (drp_drdy) begin
                    rd_capture = 1'b1;
                    next_state = rd_only_q ? S_DONE : S_WR_REQ;
                end else if (cnt == DRDY_LAST) begin
                    wait_expired = 1'b1;
                    next_state   = S_DONE;
                end
            end
            S_WR_REQ: next_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    next_state = S_REL;
                end else if (cnt == DRDY_LAST) begin
                    wait_expired = 1'b1;
                    next_state   = S_DONE;
                end
            end
`ifdef TRIG_DRP_LOCK_WAIT_EN
            S_REL: next_state = S_LOCK_WAIT;
            S_LOCK_WAIT: begin
                if (mmcm_locked) begin
                    next_state = S_DONE;
                end else if (cnt == LOCK_LAST) begin
                    wait_expired = 1'b1;
                    next_state   = S_DONE;
                end
            end
`else
            S_REL:       next_state = S_DONE;
            S_LOCK_WAIT: next_state = S_DONE;
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign in_wait = (state == S_RD_WAIT) || (state == S_WR_WAIT) || (state == S_LOCK_WAIT);

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rd_only_q  <= 1'b0;
            mask_q     <= '0;
            data_q     <= '0;
            drp_addr   <= '0;
            drp_din    <= '0;
            O_rdata    <= '0;
            O_error    <= 1'b0;
            mmcm_reset <= 1'b0;
        end else begin
            state <= next_state;

            if (in_wait && (next_state == state)) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            if (accept) begin
                rd_only_q <= I_rd_only;
                drp_addr  <= I_addr;
                mask_q    <= I_mask;
                data_q    <= I_data;
                O_error   <= 1'b0;
            end

            // Held through RST..REL; dropped leaving REL or on any timeout
            if (accept && !I_rd_only) begin
                mmcm_reset <= 1'b1;
            end else if ((state == S_REL) || wait_expired) begin
                mmcm_reset <= 1'b0;
            end

            if (rd_capture) begin
                O_rdata <= drp_dout;
                if (!rd_only_q) begin
                    drp_din <= (drp_dout & mask_q) | (data_q & ~mask_q);
                end
            end

            if (wait_expired) begin
                O_error <= 1'b1;
            end
        end
    end

    assign O_busy  = (state != S_IDLE);
    assign O_done  = (state == S_DONE);
    assign drp_den = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign drp_dwe = (state == S_WR_REQ);

endmodule

// File: tb/tb_trig_drp_sequencer.sv
// tb/tb_trig_drp_sequencer.sv - directed self-checking bench for trig_drp_sequencer

module tb_trig_drp_sequencer;

    logic        usb_clk;
    logic        reset_n;
    logic        I_start;
    logic        I_rd_only;
    logic [6:0]  I_addr;
    logic [15:0] I_mask;
    logic [15:0] I_data;
    logic        O_busy;
    logic        O_done;
    logic [15:0] O_rdata;
    logic        O_error;
    logic [6:0]  drp_addr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_din;
    logic [15:0] drp_dout;
    logic        drp_drdy;
    logic        mmcm_reset;
    logic        mmcm_locked;

    int errors;
    int checks;

    int den_cnt;
    int dwe_cnt;
    int done_cnt;
    int rst_cnt;

    trig_drp_sequencer #(
        .pDRDY_TIMEOUT(64),
        .pLOCK_TIMEOUT(65535)
    ) dut (
        .usb_clk    (usb_clk),
        .reset_n    (reset_n),
        .I_start    (I_start),
        .I_rd_only  (I_rd_only),
        .I_addr     (I_addr),
        .I_mask     (I_mask),
        .I_data     (I_data),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_rdata    (O_rdata),
        .O_error    (O_error),
        .drp_addr   (drp_addr),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_din    (drp_din),
        .drp_dout   (drp_dout),
        .drp_drdy   (drp_drdy),
        .mmcm_reset (mmcm_reset),
        .mmcm_locked(mmcm_locked)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    // Event counters sampled on the falling edge
    initial begin
        den_cnt  = 0;
        dwe_cnt  = 0;
        done_cnt = 0;
        rst_cnt  = 0;
    end
    always @(negedge usb_clk) begin
        if (drp_den)    den_cnt  = den_cnt + 1;
        if (drp_dwe)    dwe_cnt  = dwe_cnt + 1;
        if (O_done)     done_cnt = done_cnt + 1;
        if (mmcm_reset) rst_cnt  = rst_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},  32'(O_busy),     32'h0);
        check({tag, " done"},  32'(O_done),     32'h0);
        check({tag, " error"}, 32'(O_error),    32'h0);
        check({tag, " rdata"}, 32'(O_rdata),    32'h0);
        check({tag, " den"},   32'(drp_den),    32'h0);
        check({tag, " dwe"},   32'(drp_dwe),    32'h0);
        check({tag, " addr"},  32'(drp_addr),   32'h0);
        check({tag, " din"},   32'(drp_din),    32'h0);
        check({tag, " mrst"},  32'(mmcm_reset), 32'h0);
    endtask

    // Full read-modify-write from IDLE; optionally drives a drdy coincident with the read den
    task automatic run_rmw(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                           input logic [15:0] rv, input logic [15:0] exp_din,
                           input logic [15:0] prev_rdata, input bit coincident);
        int den0;
        int dwe0;
        int done0;
        den0  = den_cnt;
        dwe0  = dwe_cnt;
        done0 = done_cnt;
        I_start = 1'b1; I_rd_only = 1'b0; I_addr = a; I_mask = m; I_data = d;
        step();                                  // RST
        I_start = 1'b0; I_addr = 7'h7f; I_mask = 16'h0000; I_data = 16'hFFFF;
        check("rmw rst mrst", 32'(mmcm_reset), 32'h1);
        check("rmw rst den",  32'(drp_den),    32'h0);
        check("rmw rst busy", 32'(O_busy),     32'h1);
        step();                                  // RD_REQ
        check("rmw rd den",  32'(drp_den),  32'h1);
        check("rmw rd dwe",  32'(drp_dwe),  32'h0);
        check("rmw rd addr", 32'(drp_addr), 32'(a));
        if (coincident) begin
            drp_drdy = 1'b1; drp_dout = 16'hFFFF;
        end
        step();                                  // RD_WAIT
        check("rmw rdwait den",   32'(drp_den), 32'h0);
        check("rmw rdwait rdata", 32'(O_rdata), 32'(prev_rdata));
        drp_drdy = 1'b1; drp_dout = rv;
        step();                                  // WR_REQ
        drp_drdy = 1'b0;
        check("rmw wr den",   32'(drp_den),    32'h1);
        check("rmw wr dwe",   32'(drp_dwe),    32'h1);
        check("rmw wr din",   32'(drp_din),    32'(exp_din));
        check("rmw wr rdata", 32'(O_rdata),    32'(rv));
        check("rmw wr mrst",  32'(mmcm_reset), 32'h1);
        step();                                  // WR_WAIT
        check("rmw wrwait den", 32'(drp_den), 32'h0);
        check("rmw wrwait dwe", 32'(drp_dwe), 32'h0);
        drp_drdy = 1'b1;
        step();                                  // REL
        drp_drdy = 1'b0;
        check("rmw rel mrst", 32'(mmcm_reset), 32'h1);
        check("rmw rel done", 32'(O_done),     32'h0);
        step();
`ifdef TRIG_DRP_LOCK_WAIT_EN
        check("rmw lock done", 32'(O_done),     32'h0);
        check("rmw lock mrst", 32'(mmcm_reset), 32'h0);
        step();
        step();
        mmcm_locked = 1'b1;
        step();
`endif
        check("rmw done",       32'(O_done),     32'h1);
        check("rmw done error", 32'(O_error),    32'h0);
        check("rmw done mrst",  32'(mmcm_reset), 32'h0);
        step();                                  // IDLE
        mmcm_locked = 1'b0;
        check("rmw idle busy", 32'(O_busy), 32'h0);
        check("rmw den pulses",  32'(den_cnt - den0),   32'd2);
        check("rmw dwe pulses",  32'(dwe_cnt - dwe0),   32'd1);
        check("rmw done pulses", 32'(done_cnt - done0), 32'd1);
    endtask

    initial begin
        int den0;
        int dwe0;
        int done0;
        int rst0;
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        I_start = 1'b0; I_rd_only = 1'b0; I_addr = '0; I_mask = '0; I_data = '0;
        drp_dout = '0; drp_drdy = 1'b0; mmcm_locked = 1'b0;

        step(); step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();

        // Read-only at 0x08, drdy three cycles after den
        den0 = den_cnt; dwe0 = dwe_cnt; done0 = done_cnt; rst0 = rst_cnt;
        I_start = 1'b1; I_rd_only = 1'b1; I_addr = 7'h08;
        step();                                  // RD_REQ
        I_start = 1'b0; I_addr = 7'h55;
        check("rd den",  32'(drp_den),    32'h1);
        check("rd dwe",  32'(drp_dwe),    32'h0);
        check("rd addr", 32'(drp_addr),   32'h08);
        check("rd mrst", 32'(mmcm_reset), 32'h0);
        step();
        check("rd wait den", 32'(drp_den), 32'h0);
        step();
        step();
        drp_drdy = 1'b1; drp_dout = 16'h1234;
        step();                                  // DONE
        drp_drdy = 1'b0;
        check("rd done",  32'(O_done),  32'h1);
        check("rd rdata", 32'(O_rdata), 32'h1234);
        step();
        check("rd idle done", 32'(O_done), 32'h0);
        check("rd idle busy", 32'(O_busy), 32'h0);
        check("rd den pulses",  32'(den_cnt - den0),   32'd1);
        check("rd dwe pulses",  32'(dwe_cnt - dwe0),   32'd0);
        check("rd mrst cycles", 32'(rst_cnt - rst0),   32'd0);
        check("rd done pulses", 32'(done_cnt - done0), 32'd1);

        // RMW at 0x09: (0x5A5A & 0xFF00) | (0x00AB & 0x00FF) = 0x5AAB
        run_rmw(7'h09, 16'hFF00, 16'h00AB, 16'h5A5A, 16'h5AAB, 16'h1234, 1'b1);

        // drdy never arrives: 64 RD_WAIT cycles then timeout
        dwe0 = dwe_cnt; done0 = done_cnt;
        I_start = 1'b1; I_rd_only = 1'b1; I_addr = 7'h03;
        step();                                  // RD_REQ
        I_start = 1'b0;
        step();                                  // first RD_WAIT cycle
        for (int i = 0; i < 63; i++) step();
        check("to last wait busy",  32'(O_busy),  32'h1);
        check("to last wait done",  32'(O_done),  32'h0);
        check("to last wait error", 32'(O_error), 32'h0);
        step();                                  // DONE
        check("to done",  32'(O_done),     32'h1);
        check("to error", 32'(O_error),    32'h1);
        check("to mrst",  32'(mmcm_reset), 32'h0);
        check("to rdata", 32'(O_rdata),    32'h5A5A);
        step();
        check("to sticky error",  32'(O_error), 32'h1);
        check("to no write",      32'(dwe_cnt - dwe0),   32'd0);
        check("to done pulses",   32'(done_cnt - done0), 32'd1);

        // Next accepted start clears error; second start mid-wait ignored
        den0 = den_cnt; done0 = done_cnt;
        I_start = 1'b1; I_rd_only = 1'b1; I_addr = 7'h11;
        step();                                  // RD_REQ
        I_start = 1'b0;
        check("clr error", 32'(O_error), 32'h0);
        step();                                  // RD_WAIT
        I_start = 1'b1; I_rd_only = 1'b0; I_addr = 7'h22;
        step();
        I_start = 1'b0;
        check("ign addr", 32'(drp_addr),   32'h11);
        check("ign den",  32'(drp_den),    32'h0);
        check("ign mrst", 32'(mmcm_reset), 32'h0);
        drp_drdy = 1'b1; drp_dout = 16'hBEEF;
        step();                                  // DONE
        drp_drdy = 1'b0;
        check("ign done",  32'(O_done),  32'h1);
        check("ign rdata", 32'(O_rdata), 32'hBEEF);
        step();
        step();
        check("ign idle busy",   32'(O_busy), 32'h0);
        check("ign den pulses",  32'(den_cnt - den0),   32'd1);
        check("ign done pulses", 32'(done_cnt - done0), 32'd1);

        // drdy on the final wait cycle counts as success
        I_start = 1'b1; I_rd_only = 1'b1; I_addr = 7'h04;
        step();
        I_start = 1'b0;
        step();
        for (int i = 0; i < 63; i++) step();
        drp_drdy = 1'b1; drp_dout = 16'h0F0F;
        step();
        drp_drdy = 1'b0;
        check("edge done",  32'(O_done),  32'h1);
        check("edge error", 32'(O_error), 32'h0);
        check("edge rdata", 32'(O_rdata), 32'h0F0F);
        step();

        // Reset asserted during WR_WAIT
        done0 = done_cnt;
        I_start = 1'b1; I_rd_only = 1'b0; I_addr = 7'h0A; I_mask = 16'h00FF; I_data = 16'h1200;
        step();                                  // RST
        I_start = 1'b0;
        step();                                  // RD_REQ
        step();                                  // RD_WAIT
        drp_drdy = 1'b1; drp_dout = 16'h3456;
        step();                                  // WR_REQ
        drp_drdy = 1'b0;
        step();                                  // WR_WAIT
        check("abort busy before", 32'(O_busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        step();
        step();
        check("abort no done", 32'(done_cnt - done0), 32'd0);
        reset_n = 1'b1;
        step();
        // (0xC3C3 & 0x0F0F) | (0xA5A5 & 0xF0F0) = 0x0303 | 0xA0A0 = 0xA3A3
        run_rmw(7'h0C, 16'h0F0F, 16'hA5A5, 16'hC3C3, 16'hA3A3, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
